// File: rtl/conv_8_32.sv
// conv_8_32 -- byte-to-word assembler.
//
// Collects four consecutive valid bytes and emits one 32-bit word with a
// single-cycle valid pulse. It reverses the 32-to-8 serializer on the
// receive side of the link.
//
// Parameters:
//   LSB_FIRST  1: byte 0 -> [7:0], byte 3 -> [31:24]
//              0: byte 0 -> [31:24], byte 3 -> [7:0]
// Ports:
//   clk         rising-edge clock
//   reset_L     synchronous active-low reset; wins over valid_in
//   valid_in    dataIn holds a valid byte this cycle
//   dataIn      incoming byte
//   dataOut     last assembled word; changes only when a word completes
//   valid_out   one-cycle pulse marking a dataOut update
//   byte_count  bytes held in the partial word (0-3)
module conv_8_32 #(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        reset_L,
    input  logic        valid_in,
    input  logic [7:0]  dataIn,
    output logic [31:0] dataOut,
    output logic        valid_out,
    output logic [1:0]  byte_count
);

    // Bytes 0..2 of the word being built, byte 0 in [7:0].
    logic [23:0] partial;
    logic [1:0]  count;

    assign byte_count = count;

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            partial   <= '0;
            count     <= '0;
            dataOut   <= '0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            if (valid_in) begin
                // The 2-bit counter wraps to 0 after byte 3.
                count <= count + 2'd1;
                case (count)
                    2'd0: partial[7:0]   <= dataIn;
                    2'd1: partial[15:8]  <= dataIn;
                    2'd2: partial[23:16] <= dataIn;
                    default: begin
                        // Stale partial bytes are left in place; every slot
                        // is rewritten before it is used in the next word.
                        if (LSB_FIRST)
                            dataOut <= {dataIn, partial};
                        else
                            dataOut <= {partial[7:0], partial[15:8],
                                        partial[23:16], dataIn};
                        valid_out <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_conv_8_32.sv
// Testbench for conv_8_32: table of per-cycle vectors for the LSB_FIRST=1
// instance, plus a hand-written serializer loopback checking both byte orders.
module tb_conv_8_32;

    logic        clk = 1'b0;
    logic        reset_L;
    logic        valid_in;
    logic [7:0]  dataIn;
    logic [31:0] data_lsb, data_msb;
    logic        vout_lsb, vout_msb;
    logic [1:0]  cnt_lsb, cnt_msb;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    conv_8_32 #(.LSB_FIRST(1'b1)) dut (
        .clk(clk), .reset_L(reset_L), .valid_in(valid_in), .dataIn(dataIn),
        .dataOut(data_lsb), .valid_out(vout_lsb), .byte_count(cnt_lsb)
    );

    conv_8_32 #(.LSB_FIRST(1'b0)) dut_msb (
        .clk(clk), .reset_L(reset_L), .valid_in(valid_in), .dataIn(dataIn),
        .dataOut(data_msb), .valid_out(vout_msb), .byte_count(cnt_msb)
    );

    typedef struct {
        logic        rst_n;
        logic        vin;
        logic [7:0]  din;
        logic        exp_vout;
        logic [31:0] exp_data;
        logic [1:0]  exp_cnt;
        string       tag;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic v, input logic [7:0] d,
                                input logic ev, input logic [31:0] ed,
                                input logic [1:0] ec, input string t);
        vec_t e;
        e.rst_n = r; e.vin = v; e.din = d;
        e.exp_vout = ev; e.exp_data = ed; e.exp_cnt = ec; e.tag = t;
        vecs.push_back(e);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One cycle: drive on the falling edge, sample 1 ns after the rising edge.
    task automatic step(input logic r, input logic v, input logic [7:0] d);
        @(negedge clk);
        reset_L  = r;
        valid_in = v;
        dataIn   = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] word;
        int pulses_lsb, pulses_msb;

        reset_L = 1'b0; valid_in = 1'b0; dataIn = '0;

        // Reset held with valid_in high: nothing may be captured.
        add(0, 1, 8'hFF, 0, 32'h0, 2'd0, "reset0");
        add(0, 1, 8'hFF, 0, 32'h0, 2'd0, "reset1");
        // Basic word.
        add(1, 1, 8'h44, 0, 32'h0, 2'd1, "basic_b0");
        add(1, 1, 8'h33, 0, 32'h0, 2'd2, "basic_b1");
        add(1, 1, 8'h22, 0, 32'h0, 2'd3, "basic_b2");
        add(1, 1, 8'h11, 1, 32'h1122_3344, 2'd0, "basic_b3");
        add(1, 0, 8'h00, 0, 32'h1122_3344, 2'd0, "basic_idle");
        // Gapped input, 3 idle cycles of 8'hAA between bytes.
        add(1, 1, 8'h44, 0, 32'h1122_3344, 2'd1, "gap_b0");
        for (int i = 0; i < 3; i++) add(1, 0, 8'hAA, 0, 32'h1122_3344, 2'd1, "gap_g0");
        add(1, 1, 8'h33, 0, 32'h1122_3344, 2'd2, "gap_b1");
        for (int i = 0; i < 3; i++) add(1, 0, 8'hAA, 0, 32'h1122_3344, 2'd2, "gap_g1");
        add(1, 1, 8'h22, 0, 32'h1122_3344, 2'd3, "gap_b2");
        for (int i = 0; i < 3; i++) add(1, 0, 8'hAA, 0, 32'h1122_3344, 2'd3, "gap_g2");
        add(1, 1, 8'h11, 1, 32'h1122_3344, 2'd0, "gap_b3");
        add(1, 0, 8'hAA, 0, 32'h1122_3344, 2'd0, "gap_idle");
        // Back-to-back, two words with no bubble.
        add(1, 1, 8'h00, 0, 32'h1122_3344, 2'd1, "b2b_0");
        add(1, 1, 8'h01, 0, 32'h1122_3344, 2'd2, "b2b_1");
        add(1, 1, 8'h02, 0, 32'h1122_3344, 2'd3, "b2b_2");
        add(1, 1, 8'h03, 1, 32'h0302_0100, 2'd0, "b2b_3");
        add(1, 1, 8'h04, 0, 32'h0302_0100, 2'd1, "b2b_4");
        add(1, 1, 8'h05, 0, 32'h0302_0100, 2'd2, "b2b_5");
        add(1, 1, 8'h06, 0, 32'h0302_0100, 2'd3, "b2b_6");
        add(1, 1, 8'h07, 1, 32'h0706_0504, 2'd0, "b2b_7");
        add(1, 0, 8'h00, 0, 32'h0706_0504, 2'd0, "b2b_idle");
        // Reset mid-word; reset also clears dataOut and beats valid_in.
        add(1, 1, 8'hAB, 0, 32'h0706_0504, 2'd1, "mid_ab");
        add(1, 1, 8'hCD, 0, 32'h0706_0504, 2'd2, "mid_cd");
        add(0, 1, 8'hEE, 0, 32'h0, 2'd0, "mid_reset");
        add(1, 1, 8'h01, 0, 32'h0, 2'd1, "mid_b0");
        add(1, 1, 8'h02, 0, 32'h0, 2'd2, "mid_b1");
        add(1, 1, 8'h03, 0, 32'h0, 2'd3, "mid_b2");
        add(1, 1, 8'h04, 1, 32'h0403_0201, 2'd0, "mid_b3");
        add(1, 0, 8'h00, 0, 32'h0403_0201, 2'd0, "mid_idle");

        foreach (vecs[i]) begin
            step(vecs[i].rst_n, vecs[i].vin, vecs[i].din);
            chk({vecs[i].tag, ".valid_out"}, {31'b0, vout_lsb},  {31'b0, vecs[i].exp_vout});
            chk({vecs[i].tag, ".dataOut"},   data_lsb,           vecs[i].exp_data);
            chk({vecs[i].tag, ".byte_count"}, {30'b0, cnt_lsb},  {30'b0, vecs[i].exp_cnt});
        end

        // Loopback: model the serializer (byte 0 = word[7:0]) feeding both
        // instances from serializer count 0.
        word = 32'hDEAD_BEEF;
        pulses_lsb = 0; pulses_msb = 0;
        for (int k = 0; k < 4; k++) begin
            step(1, 1, word[8*k +: 8]);
            if (vout_lsb) pulses_lsb++;
            if (vout_msb) pulses_msb++;
        end
        chk("loop_lsb.dataOut", data_lsb, 32'hDEAD_BEEF);
        chk("loop_msb.dataOut", data_msb, 32'hEFBE_ADDE);
        chk("loop_lsb.pulse_on_last", {31'b0, vout_lsb}, 32'd1);
        chk("loop_msb.pulse_on_last", {31'b0, vout_msb}, 32'd1);
        chk("loop_lsb.pulses", pulses_lsb, 32'd1);
        chk("loop_msb.pulses", pulses_msb, 32'd1);
        step(1, 0, 8'h00);
        chk("loop_lsb.pulse_single", {31'b0, vout_lsb}, 32'd0);
        chk("loop_msb.hold", data_msb, 32'hEFBE_ADDE);
        chk("loop_msb.byte_count", {30'b0, cnt_msb}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_8_32.md
# conv_8_32

Byte-to-word assembler: collects four consecutive valid 8-bit bytes and emits one 32-bit word with a one-cycle valid pulse. It sits directly downstream of the 32-to-8 serializer. It undoes that serialization so the receive side of the link sees the original 32-bit words. Byte order matches the serializer: the first byte of a word is bits [7:0] and the fourth is bits [31:24].

## Interface
- LSB_FIRST, 1, byte order.
  - 1: byte 0 goes to [7:0], byte 3 to [31:24].
  - 0: byte 0 goes to [31:24], byte 3 to [7:0].
- clk  input  1  single clock; all state updates on its rising edge.
- reset_L  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- valid_in  input  1  dataIn carries a valid byte this cycle.
- dataIn  input  8  incoming byte.
- dataOut  output  32  last assembled word; registered.
- valid_out  output  1  one-cycle pulse: dataOut was updated on this edge.
- byte_count  output  2  number of bytes currently held in the partial word (0–3); registered.

## Operation
- Reset behaviour: reset_L sampled low at a rising edge clears all state.
  - dataOut = 32'h0000_0000, valid_out = 0, byte_count = 0.
  - The internal partial-word register is cleared to 0.
  - Reset has priority over valid_in on the same edge.
- Internal state: 2-bit byte counter (exported as byte_count) and a 24-bit partial register holding bytes 0–2.
- Edge with valid_in = 1 and byte_count = 0, 1 or 2:
  - dataIn is stored into the byte-lane slot selected by byte_count.
  - byte_count increments by 1; valid_out = 0.
- Edge with valid_in = 1 and byte_count = 3:
  - dataOut is loaded with {dataIn, partial bytes 2, 1, 0} (LSB_FIRST = 1), or the mirrored order (LSB_FIRST = 0).
  - valid_out = 1 for this one cycle only.
  - byte_count wraps to 0.
  - The partial register need not be cleared; unused slots are overwritten before they are used again.
- Edge with valid_in = 0:
  - byte_count and the partial register hold.
  - valid_out = 0; dataOut holds.
  - Gaps of any length between bytes are legal and do not break word alignment.
- dataOut holds its last value until the next complete word. It is never updated with a partial word.
- No backpressure: the consumer must accept a word in the cycle valid_out is high.
- Reset mid-word: any partial bytes are discarded, with no valid_out. The next valid byte is treated as byte 0.

## Timing
- Throughput: one word per 4 valid bytes; a sustained word every 4 cycles when valid_in is held high.
- Latency: dataOut and valid_out change on the same rising edge that samples the 4th byte. They are visible in the following cycle, i.e. 1 cycle after byte 3 is presented.
- Back-to-back words: the byte presented on the cycle after valid_out goes high is byte 0 of the next word. No bubble is required.
- valid_out is never high on two consecutive cycles.
- byte_count reflects the state after the most recent edge. It is 0 in the cycle valid_out is high.

## Test plan
- Reset: hold reset_L = 0 for 2 cycles with valid_in = 1 and dataIn = 8'hFF.
  - Required: dataOut = 0, valid_out = 0 and byte_count = 0 throughout.
- Basic word (LSB_FIRST = 1): bytes 8'h44, 8'h33, 8'h22, 8'h11 on 4 consecutive cycles.
  - Required: one valid_out pulse, dataOut = 32'h1122_3344, 1 cycle after 8'h11 is presented.
  - Required: byte_count sequence 1, 2, 3, 0.
- Gapped input: same four bytes with valid_in = 0 for 3 cycles between each byte, dataIn = 8'hAA during the gaps.
  - Required: identical dataOut = 32'h1122_3344, one pulse only.
  - Required: the gap values are never captured.
- Back-to-back: 8 bytes 8'h00..8'h07 with valid_in held high.
  - Required: valid_out pulses exactly twice, 4 cycles apart.
  - Required: dataOut = 32'h0302_0100, then 32'h0706_0504.
- Reset mid-word: send 8'hAB, 8'hCD, then pulse reset_L low for 1 cycle, then send 8'h01, 8'h02, 8'h03, 8'h04.
  - Required: no pulse before or during reset.
  - Required: one pulse with dataOut = 32'h0403_0201.
- Loopback: serializer output feeds this block, with valid_in high from the cycle the serializer counter is 0; apply word 32'hDEAD_BEEF.
  - Required: dataOut = 32'hDEAD_BEEF.
  - With LSB_FIRST = 0 the required result is 32'hEFBE_ADDE.
